imm_inst_encoder: RTL
=====================

Name: imm_inst_encoder

Overview:
- Inverse of the decode-side immediate extraction: packs register fields and a 32-bit immediate into RISC-V RV32I instruction words.
- Requests arrive on a valid/ready input. Encoded words leave on a valid/ready output.
- An out-of-range load-immediate is expanded into a LUI+ADDI pair.
- Feeds instruction memory / test-program loaders in the simplest_rtl core.

Parameters:
CNT_W, 16, width of the emitted-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_type  in  `TYPE_BUS  `INST_R or `INST_I (from define.v)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2 (R only)
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  `Reg_Bus  signed 32-bit immediate (I only)
out_valid  out  1  encoded word valid
out_ready  in  1  sink accepts word
out_inst  out  `Reg_Bus  encoded instruction
out_last  out  1  word is last of its request
inst_count  out  CNT_W  count of out handshakes, wraps at 2^CNT_W
err  out  1  sticky: a request was rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_inst=0, out_last=0, inst_count=0, err=0, pending word cleared. Reset mid-pair discards both words.
- Encoding rules:
  - R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - I-type, imm in [-2048, 2047]: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
- Split (I-type, imm out of range, funct3==000, rs1==0):
  - hi20 = (imm + 32'h800) >> 12, 32-bit wrap; lo12 = imm[11:0].
  - Word 1: LUI {hi20, rd, 7'b0110111}, out_last=0.
  - Word 2: ADDI {lo12, rd, 3'b000, rd, 7'b0010011}, out_last=1.
  - Both words are always emitted, even if lo12==0.
- Reject: an out-of-range I-type that does not meet the split condition, or an in_type other than R/I.
  - The request is consumed and no word is output.
  - err is set the cycle after acceptance and stays set until reset.
- States:
  - IDLE: no word held.
  - ONE: out_inst holds the final word.
  - FIRST: out_inst holds LUI; ADDI is held in the pending register.
- in_ready = (state==IDLE) || (state==ONE && out_ready). Combinational; allows 1 request/cycle throughput.
- On accept: the encoded word is registered with 1-cycle latency (out_valid the next cycle). Next state is ONE, FIRST, or IDLE (reject).
- ONE & out_ready & no accept -> IDLE. ONE & out_ready & accept -> new word loaded the same edge.
- FIRST & out_ready -> ONE with the ADDI word loaded. FIRST holds while out_ready=0.
- Output stability: out_inst/out_last stay stable while out_valid && !out_ready.
- inst_count increments on every out_valid && out_ready and wraps to 0 after all-ones.

Optional Feature:
IMM_SPLIT_EN
- Defined: LUI+ADDI split as above.
- Undefined: every out-of-range I-type is rejected (err set, no output); FIRST state and pending register are not built.

Test Plan:
1. After reset: out_valid=0, inst_count=0, err=0, in_ready=1.
2. R add x3,x1,x2 (funct7=0, funct3=0) with out_ready=1 -> next cycle out_inst=32'h002081B3, out_last=1; inst_count=1.
3. I addi x1,x0,-5 -> 32'hFFB00093. Then imm=2047 -> 32'h7FF00093, single word.
4. Split with IMM_SPLIT_EN:
   - rd=1, rs1=0, imm=2048 -> 32'h000010B7 (last=0) then 32'h80008093 (last=1).
   - rd=5, imm=32'h12345FFF -> 32'h123462B7 then 32'hFFF28293.
   - in_ready=0 during FIRST.
5. Backpressure: hold out_ready=0 for 5 cycles mid-pair -> LUI word stable, in_ready=0, inst_count unchanged. Release -> ADDI follows, count +2 total.
6. imm=4096 with rs1=2 (or IMM_SPLIT_EN undefined) -> no output, err=1 until reset. Apply rst_n=0 mid-pair -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: packs register fields and a 32-bit immediate into RV32I words.
// Optional feature IMM_SPLIT_EN expands an out-of-range load-immediate into LUI+ADDI.
`ifndef TYPE_BUS
`define TYPE_BUS 2:0
`endif
`ifndef INST_R
`define INST_R 3'b001
`endif
`ifndef INST_I
`define INST_I 3'b010
`endif
`ifndef Reg_Bus
`define Reg_Bus 31:0
`endif

module imm_inst_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [`TYPE_BUS] in_type,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [`Reg_Bus]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [`Reg_Bus]  out_inst,
  output logic             out_last,
  output logic [CNT_W-1:0] inst_count,
  output logic             err
);

`ifdef IMM_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE, S_ONE, S_FIRST} state_t;
`else
  typedef enum logic {S_IDLE, S_ONE} state_t;
`endif

  state_t          r_state;
  logic            r_out_valid;
  logic [31:0]     r_out_inst;
  logic            r_out_last;
  logic [CNT_W-1:0] r_count;
  logic            r_err;

  logic        w_is_r;
  logic        w_is_i;
  logic        w_in_range;
  logic        w_single;
  logic        w_accept;
  logic        w_fire;
  logic [31:0] w_word;

  assign w_is_r     = (in_type == `INST_R);
  assign w_is_i     = (in_type == `INST_I);
  // Fits the signed 12-bit field when bits [31:11] are pure sign extension.
  assign w_in_range = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign w_single   = w_is_r || (w_is_i && w_in_range);
  assign w_word     = w_is_r ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011}
                             : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};

`ifdef IMM_SPLIT_EN
  logic [31:0] r_pending;
  logic        w_split;
  logic [31:0] w_sum;
  logic [31:0] w_lui;
  logic [31:0] w_addi;

  assign w_split = w_is_i && !w_in_range && (in_funct3 == 3'b000) && (in_rs1 == 5'd0);
  // Rounding by 0x800 compensates for ADDI sign-extending lo12.
  assign w_sum   = in_imm + 32'h0000_0800;
  assign w_lui   = {w_sum[31:12], in_rd, 7'b0110111};
  assign w_addi  = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'b0010011};
`endif

  assign in_ready = (r_state == S_IDLE) || ((r_state == S_ONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_last  <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
`ifdef IMM_SPLIT_EN
      r_pending   <= '0;
`endif
    end else begin
      if (w_fire)
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_accept) begin
        if (w_single) begin
          r_state     <= S_ONE;
          r_out_valid <= 1'b1;
          r_out_inst  <= w_word;
          r_out_last  <= 1'b1;
        end
`ifdef IMM_SPLIT_EN
        else if (w_split) begin
          r_state     <= S_FIRST;
          r_out_valid <= 1'b1;
          r_out_inst  <= w_lui;
          r_out_last  <= 1'b0;
          r_pending   <= w_addi;
        end
`endif
        else begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_err       <= 1'b1;
        end
      end else begin
        case (r_state)
          S_ONE: begin
            if (out_ready) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
`ifdef IMM_SPLIT_EN
          S_FIRST: begin
            if (out_ready) begin
              r_state    <= S_ONE;
              r_out_inst <= r_pending;
              r_out_last <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_inst   = r_out_inst;
  assign out_last   = r_out_last;
  assign inst_count = r_count;
  assign err        = r_err;

endmodule
